// File: rtl/noc_fifo_pkg.sv
// Shared types and field positions for the virtual-channel flit FIFO.
// The head-address field is the low nibble of each flit.
package noc_fifo_pkg;
  localparam int FLIT_WIDTH = 18;
  localparam int MAX_VC     = 4;
  localparam int VC_ID_W    = $clog2(MAX_VC);
  localparam int ADDR_LSB   = 0;
  localparam int ADDR_MSB   = 3;
  localparam int ADDR_W     = ADDR_MSB - ADDR_LSB + 1;

  typedef logic [VC_ID_W-1:0]    vc_id_t;
  typedef logic [FLIT_WIDTH-1:0] flit_t;
endpackage

// File: rtl/vc_fifo_bank.sv
// One VC's circular flit store: head flit visible combinationally, count updated the edge after push/pop.
// No internal backpressure; the parent only issues push when not full and pop when not empty.
module vc_fifo_bank
  import noc_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = FLIT_WIDTH,
  parameter int  VC_DEPTH   = 8,
  localparam int PTR_W      = $clog2(VC_DEPTH),
  localparam int CNT_W      = $clog2(VC_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ADDR_W-1:0]     head_addr,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [VC_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Storage is deliberately left out of reset; nothing reads it while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign head_addr = (count == '0) ? '0 : head_data[ADDR_MSB:ADDR_LSB];

endmodule

// File: rtl/vc_fifo.sv
// Multi-VC flit FIFO: write/read accepted on pre-edge status, rd_data/rd_valid/credit one cycle after a pop.
// Writes to a full VC and reads from an empty VC are dropped and latched as sticky ovf_err/udf_err.
module vc_fifo
  import noc_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = FLIT_WIDTH,
  parameter int  NUM_VC     = MAX_VC,
  parameter int  VC_DEPTH   = 8,
  parameter int  AF_LEVEL   = VC_DEPTH - 2,
  localparam int VC_W       = $clog2(NUM_VC),
  localparam int CNT_W      = $clog2(VC_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [VC_W-1:0]           wr_vc,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  input  logic [VC_W-1:0]           rd_vc,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic [NUM_VC-1:0]         full,
  output logic [NUM_VC-1:0]         empty,
  output logic [NUM_VC-1:0]         almost_full,
  output logic [NUM_VC*CNT_W-1:0]   count,
  output logic [NUM_VC*ADDR_W-1:0]  head_addr,
  output logic [NUM_VC-1:0]         credit,
  output logic                      ovf_err,
  output logic                      udf_err
);

  logic [NUM_VC-1:0]     push;
  logic [NUM_VC-1:0]     pop;
  logic [DATA_WIDTH-1:0] head_data [NUM_VC];
  logic [CNT_W-1:0]      cnt       [NUM_VC];
  logic [DATA_WIDTH-1:0] rd_sel;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_fifo_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .VC_DEPTH   (VC_DEPTH)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .push      (push[v]),
      .pop       (pop[v]),
      .wr_data   (wr_data),
      .head_data (head_data[v]),
      .head_addr (head_addr[v*ADDR_W +: ADDR_W]),
      .count     (cnt[v])
    );

    assign count[v*CNT_W +: CNT_W] = cnt[v];
    assign full[v]        = (cnt[v] == CNT_W'(VC_DEPTH));
    assign empty[v]       = (cnt[v] == '0);
    assign almost_full[v] = (cnt[v] >= CNT_W'(AF_LEVEL));
  end

  // An out-of-range VC index matches no bank, so it is rejected like full/empty.
  always_comb begin
    push   = '0;
    pop    = '0;
    rd_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_en && (wr_vc == VC_W'(v)) && !full[v]) push[v] = 1'b1;
      if (rd_en && (rd_vc == VC_W'(v)) && !empty[v]) begin
        pop[v] = 1'b1;
        rd_sel = head_data[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      credit   <= '0;
      ovf_err  <= 1'b0;
      udf_err  <= 1'b0;
    end else begin
      rd_valid <= |pop;
      credit   <= pop;
      if (|pop)              rd_data <= rd_sel;
      if (wr_en && !(|push)) ovf_err <= 1'b1;
      if (rd_en && !(|pop))  udf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_fifo.sv
// Directed bench for vc_fifo at default parameters (18-bit flits, 4 VCs, depth 8, AF at 6).
// Outputs are sampled 1ns after each rising edge; inputs change at the same point.
module tb_vc_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_vc = '0;
  logic [17:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_vc = '0;
  logic [17:0] rd_data;
  logic        rd_valid;
  logic [3:0]  full, empty, almost_full, credit;
  logic [15:0] count, head_addr;
  logic        ovf_err, udf_err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  vc_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_vc       (wr_vc),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_vc       (rd_vc),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .head_addr   (head_addr),
    .credit      (credit),
    .ovf_err     (ovf_err),
    .udf_err     (udf_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cnt_of(input int v);
    return count[v*4 +: 4];
  endfunction

  function automatic logic [3:0] ha_of(input int v);
    return head_addr[v*4 +: 4];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          ncred;
    int          k;
    int          n3;
    logic        exp_vld;
    logic [17:0] last;

    // reset state
    tick;
    tick;
    check("rst rd_valid", rd_valid, 0);
    check("rst rd_data", rd_data, 0);
    check("rst credit", credit, 0);
    check("rst ovf", ovf_err, 0);
    check("rst udf", udf_err, 0);
    check("rst empty", empty, 4'hF);
    check("rst full", full, 0);
    check("rst af", almost_full, 0);
    check("rst count", count, 0);
    check("rst head_addr", head_addr, 0);
    rst = 1'b1;

    // fill VC2 with 1..8
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_vc = 2'd2; wr_data = 18'(i);
      tick;
    end
    wr_en = 1'b0;
    check("fill count2", cnt_of(2), 8);
    check("fill full", full, 4'b0100);
    check("fill af", almost_full, 4'b0100);
    check("fill empty", empty, 4'b1011);
    check("fill head2", ha_of(2), 1);

    // 9th write to full VC2
    wr_en = 1'b1; wr_vc = 2'd2; wr_data = 18'h9;
    tick;
    wr_en = 1'b0;
    check("ovf count2", cnt_of(2), 8);
    check("ovf flag", ovf_err, 1);
    check("ovf no udf", udf_err, 0);

    // drain VC2
    ncred = 0;
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1; rd_vc = 2'd2;
      tick;
      check("drain rd_valid", rd_valid, 1);
      check("drain rd_data", rd_data, i);
      if (credit == 4'b0100) ncred++;
    end
    rd_en = 1'b0;
    tick;
    check("idle rd_valid", rd_valid, 0);
    check("idle credit", credit, 0);
    check("idle rd_data hold", rd_data, 8);
    check("credit pulses", ncred, 8);
    check("drain empty2", empty[2], 1);

    // refill, then read+write together at full
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_vc = 2'd2; wr_data = 18'h21 + 18'(i);
      tick;
    end
    wr_data = 18'h1F; rd_en = 1'b1; rd_vc = 2'd2;
    tick;
    wr_en = 1'b0; rd_en = 1'b0;
    check("rw@full count2", cnt_of(2), 7);
    check("rw@full rd_data", rd_data, 18'h21);
    check("rw@full full2", full[2], 0);
    check("rw@full head2", ha_of(2), 2);
    for (int i = 0; i < 7; i++) begin
      rd_en = 1'b1; rd_vc = 2'd2;
      tick;
      check("rw@full drain", rd_data, 18'h22 + 18'(i));
    end
    rd_en = 1'b0;
    tick;
    check("rw@full dropped", empty[2], 1);

    // read empty VC1 with same-cycle write to VC1
    rd_en = 1'b1; rd_vc = 2'd1; wr_en = 1'b1; wr_vc = 2'd1; wr_data = 18'h3A;
    tick;
    rd_en = 1'b0; wr_en = 1'b0;
    check("udf rd_valid", rd_valid, 0);
    check("udf flag", udf_err, 1);
    check("udf count1", cnt_of(1), 1);
    check("udf head1", ha_of(1), 4'hA);
    check("udf credit", credit, 0);
    check("udf rd_data hold", rd_data, 18'h28);

    // wrap-around on VC0 at occupancy 3
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_vc = 2'd0; wr_data = 18'h100 + 18'(i);
      tick;
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_vc = 2'd0; wr_data = 18'h103 + 18'(i);
      rd_en = 1'b1; rd_vc = 2'd0;
      tick;
      check("wrap rd_data", rd_data, 18'h100 + 18'(i));
    end
    rd_en = 1'b0;
    check("wrap count0", cnt_of(0), 3);
    check("wrap af0 low", almost_full[0], 0);
    wr_data = 18'h117;
    tick;
    wr_data = 18'h118;
    tick;
    check("af count0=5", cnt_of(0), 5);
    check("af0 at 5", almost_full[0], 0);
    wr_data = 18'h119;
    tick;
    wr_en = 1'b0;
    check("af count0=6", cnt_of(0), 6);
    check("af0 at 6", almost_full[0], 1);
    check("af1 at 1", almost_full[1], 0);

    // VC isolation: write VC3 and read VC0 every cycle
    k = 0; n3 = 0; last = 18'h113;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_vc = 2'd3; wr_data = 18'h200 + 18'(i);
      rd_en = 1'b1; rd_vc = 2'd0;
      tick;
      exp_vld = (k < 6);
      if (exp_vld) begin
        last = 18'h114 + 18'(k);
        k++;
      end
      if (n3 < 8) n3++;
      check("iso rd_valid", rd_valid, exp_vld);
      check("iso rd_data", rd_data, last);
      check("iso count0", cnt_of(0), 6 - k);
      check("iso count3", cnt_of(3), n3);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_vc = 2'd3;
      tick;
      check("iso vc3 data", rd_data, 18'h200 + 18'(i));
    end
    rd_en = 1'b0;
    check("iso count3 end", cnt_of(3), 0);
    check("iso count1 kept", cnt_of(1), 1);

    // reset with VC1 at count 5 and traffic on the reset edge
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_vc = 2'd1; wr_data = 18'h41 + 18'(i);
      tick;
    end
    wr_en = 1'b0;
    check("pre-rst count1", cnt_of(1), 5);
    rst = 1'b0; wr_en = 1'b1; wr_vc = 2'd1; rd_en = 1'b1; rd_vc = 2'd1;
    tick;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    check("mid-rst empty", empty, 4'hF);
    check("mid-rst count", count, 0);
    check("mid-rst rd_valid", rd_valid, 0);
    check("mid-rst ovf", ovf_err, 0);
    check("mid-rst udf", udf_err, 0);
    check("mid-rst credit", credit, 0);
    check("mid-rst rd_data", rd_data, 0);
    check("mid-rst head_addr", head_addr, 0);
    tick;
    check("post-rst empty", empty, 4'hF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
